// File: rtl/qnn_pkg.sv
// Shared types and helpers for the QNN streaming front-end.
// Precision codes match the layer_prec encoding presented to the core.
package qnn_pkg;

    typedef enum logic [1:0] {
        PREC_INT8 = 2'b00,
        PREC_INT4 = 2'b01,
        PREC_BIN  = 2'b10
    } prec_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_BIAS,
        ST_WGT,
        ST_ACT,
        ST_START,
        ST_WAIT,
        ST_DRAIN
    } ctrl_state_e;

    // Config word bit that requests reuse of the resident weights.
    localparam int CFG_KEEP_BIT = 2;

    // Number of operand elements packed into one 32-bit stream word.
    function automatic int elems_per_word(prec_e prec);
        case (prec)
            PREC_INT8: return 4;
            PREC_INT4: return 8;
            default:   return 32;
        endcase
    endfunction

    // Stream words needed to carry a vector of len elements.
    function automatic int words_per_vec(prec_e prec, int len);
        return len / elems_per_word(prec);
    endfunction

endpackage

// File: rtl/qnn_stream_ctrl_if.sv
// Stream bus of the QNN front-end: one inbound word stream (config,
// biases, weights, activations) and one outbound result stream.
// The slave modport is the controller side, master is the host side.
interface qnn_stream_ctrl_if;

    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );

endinterface

// File: rtl/qnn_word_unpack.sv
// Combinational split of one stream word into INT8, INT4 and binary
// lanes, least-significant element first.
module qnn_word_unpack (
    input  logic [31:0]       word,
    output logic signed [7:0] lane8 [4],
    output logic signed [3:0] lane4 [8],
    output logic [31:0]       laneb
);

    genvar gi;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane8
            assign lane8[gi] = word[gi*8 +: 8];
        end
        for (gi = 0; gi < 8; gi++) begin : g_lane4
            assign lane4[gi] = word[gi*4 +: 4];
        end
    endgenerate

    assign laneb = word;

endmodule

// File: rtl/qnn_stream_ctrl.sv
// Streaming loader and sequencer for the QNN core: takes a config word,
// then biases, weights and activations, fills the operand arrays of the
// selected precision, starts the core and streams its results back.
// Optional feature macro: QNN_WEIGHT_KEEP_EN (config bit 2 skips the
// weight phase and reuses the resident weights of that precision).
module qnn_stream_ctrl
    import qnn_pkg::*;
#(
    parameter int IN_DIM  = 64,
    parameter int OUT_DIM = 16,
    parameter int NUM_PE  = 1,
    parameter int WORD_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    qnn_stream_ctrl_if.slave         bus,
    output logic                     acc_start,
    input  logic                     acc_done,
    output logic [1:0]               layer_prec,
    output logic signed [7:0]        in8  [IN_DIM],
    output logic signed [7:0]        w8   [OUT_DIM][IN_DIM],
    output logic signed [3:0]        in4  [IN_DIM],
    output logic signed [3:0]        w4   [OUT_DIM][IN_DIM],
    output logic                     inb  [IN_DIM],
    output logic                     wb   [OUT_DIM][IN_DIM],
    output logic signed [WORD_W-1:0] bias [OUT_DIM],
    input  logic signed [WORD_W-1:0] acc_out [OUT_DIM],
    output logic                     busy,
    output logic                     err
);

    localparam int MAX_WORDS = OUT_DIM * IN_DIM / 4;
    localparam int CNT_W     = $clog2(MAX_WORDS) + 1;
    localparam int IDX_W     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    genvar gi, go;

    // NUM_PE only configures the core; a PE count below one is meaningless.
    generate
        if (NUM_PE < 1) begin : g_num_pe_invalid
        end
    endgenerate

    ctrl_state_e state_reg, state_next;
    prec_e       prec_reg;
    logic        keep_reg;
    logic        err_reg;
    logic [CNT_W-1:0] col_reg;     // word within row / vector / bias index
    logic [CNT_W-1:0] row_reg;     // weight row during WGT
    logic [IDX_W-1:0] idx_reg;     // result index during DRAIN
    logic signed [WORD_W-1:0] out_bank [OUT_DIM];

    logic [CNT_W-1:0] wpr;
    logic hs_in, hs_out;
    logic last_bias, last_col, last_row, last_out;
    logic cfg_bad, cfg_keep;
    logic we_bias, we_wgt, we_act, capture;
    logic sel8, sel4, selb;

    logic signed [7:0] lane8 [4];
    logic signed [3:0] lane4 [8];
    logic [31:0]       laneb;

    qnn_word_unpack u_unpack (
        .word  (bus.s_data),
        .lane8 (lane8),
        .lane4 (lane4),
        .laneb (laneb)
    );

    assign hs_in     = bus.s_valid && bus.s_ready;
    assign hs_out    = bus.m_valid && bus.m_ready;
    assign wpr       = CNT_W'(words_per_vec(prec_reg, IN_DIM));
    assign last_bias = (col_reg == CNT_W'(OUT_DIM - 1));
    assign last_col  = (col_reg == wpr - 1'b1);
    assign last_row  = (row_reg == CNT_W'(OUT_DIM - 1));
    assign last_out  = (idx_reg == IDX_W'(OUT_DIM - 1));
    assign cfg_bad   = (bus.s_data[1:0] == 2'b11);

`ifdef QNN_WEIGHT_KEEP_EN
    assign cfg_keep = bus.s_data[CFG_KEEP_BIT];
`else
    assign cfg_keep = 1'b0;
`endif

    assign we_bias = hs_in && (state_reg == ST_BIAS);
    assign we_wgt  = hs_in && (state_reg == ST_WGT);
    assign we_act  = hs_in && (state_reg == ST_ACT);
    assign capture = (state_reg == ST_WAIT) && acc_done;
    assign sel8    = (prec_reg == PREC_INT8);
    assign sel4    = (prec_reg == PREC_INT4);
    assign selb    = (prec_reg == PREC_BIN);

    assign bus.m_data = out_bank[idx_reg];
    assign layer_prec = prec_reg;
    assign err        = err_reg;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state and handshake/strobe outputs decoded from the current state.
    always_comb begin
        state_next  = state_reg;
        bus.s_ready = 1'b0;
        bus.m_valid = 1'b0;
        bus.m_last  = 1'b0;
        acc_start   = 1'b0;
        busy        = (state_reg != ST_IDLE);
        case (state_reg)
            ST_IDLE: begin
                if (bus.s_valid) state_next = ST_CFG;
            end
            ST_CFG: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) state_next = cfg_bad ? ST_IDLE : ST_BIAS;
            end
            ST_BIAS: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid && last_bias) state_next = keep_reg ? ST_ACT : ST_WGT;
            end
            ST_WGT: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid && last_col && last_row) state_next = ST_ACT;
            end
            ST_ACT: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid && last_col) state_next = ST_START;
            end
            ST_START: begin
                acc_start  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (acc_done) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                bus.m_valid = 1'b1;
                bus.m_last  = last_out;
                if (bus.m_ready && last_out) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Config capture, sticky error and the phase word counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prec_reg <= PREC_INT8;
            keep_reg <= 1'b0;
            err_reg  <= 1'b0;
            col_reg  <= '0;
            row_reg  <= '0;
            idx_reg  <= '0;
        end else begin
            case (state_reg)
                ST_CFG: begin
                    col_reg <= '0;
                    row_reg <= '0;
                    if (hs_in) begin
                        if (cfg_bad) begin
                            err_reg <= 1'b1;
                        end else begin
                            err_reg  <= 1'b0;
                            prec_reg <= prec_e'(bus.s_data[1:0]);
                            keep_reg <= cfg_keep;
                        end
                    end
                end
                ST_BIAS: begin
                    if (hs_in) col_reg <= last_bias ? '0 : col_reg + 1'b1;
                end
                ST_WGT: begin
                    if (hs_in) begin
                        if (last_col) begin
                            col_reg <= '0;
                            row_reg <= row_reg + 1'b1;
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
                ST_ACT: begin
                    if (hs_in) col_reg <= last_col ? '0 : col_reg + 1'b1;
                end
                ST_WAIT: begin
                    idx_reg <= '0;
                end
                ST_DRAIN: begin
                    if (hs_out) idx_reg <= idx_reg + 1'b1;
                end
                default: begin
                    col_reg <= '0;
                    row_reg <= '0;
                end
            endcase
        end
    end

    generate
        for (gi = 0; gi < IN_DIM; gi++) begin : g_act
            // Activation element gi takes its lane when its word arrives.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    in8[gi] <= '0;
                    in4[gi] <= '0;
                    inb[gi] <= 1'b0;
                end else if (we_act) begin
                    if (sel8 && col_reg == CNT_W'(gi / 4))  in8[gi] <= lane8[gi % 4];
                    if (sel4 && col_reg == CNT_W'(gi / 8))  in4[gi] <= lane4[gi % 8];
                    if (selb && col_reg == CNT_W'(gi / 32)) inb[gi] <= laneb[gi % 32];
                end
            end
        end

        for (go = 0; go < OUT_DIM; go++) begin : g_row
            for (gi = 0; gi < IN_DIM; gi++) begin : g_wgt
                // Weight element [go][gi]; a word never straddles two rows.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        w8[go][gi] <= '0;
                        w4[go][gi] <= '0;
                        wb[go][gi] <= 1'b0;
                    end else if (we_wgt && row_reg == CNT_W'(go)) begin
                        if (sel8 && col_reg == CNT_W'(gi / 4))  w8[go][gi] <= lane8[gi % 4];
                        if (sel4 && col_reg == CNT_W'(gi / 8))  w4[go][gi] <= lane4[gi % 8];
                        if (selb && col_reg == CNT_W'(gi / 32)) wb[go][gi] <= laneb[gi % 32];
                    end
                end
            end

            // Bias word go and the result register captured on core done.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bias[go]     <= '0;
                    out_bank[go] <= '0;
                end else begin
                    if (we_bias && col_reg == CNT_W'(go)) bias[go] <= bus.s_data;
                    if (capture) out_bank[go] <= acc_out[go];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_qnn_stream_ctrl.sv
// Self-checking bench for qnn_stream_ctrl (IN_DIM=32, OUT_DIM=2).
// Core results are pushed to a scoreboard queue when the modelled core
// raises done and popped as the controller drains them.
module tb_qnn_stream_ctrl;

    localparam int IN_DIM  = 32;
    localparam int OUT_DIM = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    qnn_stream_ctrl_if bus();

    logic              acc_start;
    logic              acc_done;
    logic [1:0]        layer_prec;
    logic signed [7:0] in8 [IN_DIM];
    logic signed [7:0] w8  [OUT_DIM][IN_DIM];
    logic signed [3:0] in4 [IN_DIM];
    logic signed [3:0] w4  [OUT_DIM][IN_DIM];
    logic              inb [IN_DIM];
    logic              wb  [OUT_DIM][IN_DIM];
    logic signed [31:0] bias    [OUT_DIM];
    logic signed [31:0] acc_out [OUT_DIM];
    logic              busy;
    logic              err;

    qnn_stream_ctrl #(
        .IN_DIM  (IN_DIM),
        .OUT_DIM (OUT_DIM),
        .NUM_PE  (1),
        .WORD_W  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .acc_start  (acc_start),
        .acc_done   (acc_done),
        .layer_prec (layer_prec),
        .in8        (in8),
        .w8         (w8),
        .in4        (in4),
        .w4         (w4),
        .inb        (inb),
        .wb         (wb),
        .bias       (bias),
        .acc_out    (acc_out),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Free-running monitor: handshake and start-pulse bookkeeping.
    int cyc = 0, hs_count = 0, last_hs_cyc = 0, start_count = 0, start_cyc = 0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.s_valid && bus.s_ready) begin
            hs_count    = hs_count + 1;
            last_hs_cyc = cyc;
        end
        if (acc_start) begin
            start_count = start_count + 1;
            start_cyc   = cyc;
        end
    end

    logic [31:0] stim_q [$];
    logic [31:0] exp_q  [$];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Queue a full load: config, OUT_DIM biases, nw weights, na activations.
    task automatic build_load(input logic [31:0] cfg, input logic [31:0] b0, input logic [31:0] b1,
                              input int nw, input logic [31:0] wfirst, input logic [31:0] wrest,
                              input int na, input logic [31:0] aw);
        stim_q.push_back(cfg);
        stim_q.push_back(b0);
        stim_q.push_back(b1);
        for (int i = 0; i < nw; i++) stim_q.push_back(i == 0 ? wfirst : wrest);
        for (int i = 0; i < na; i++) stim_q.push_back(aw);
    endtask

    // Send the queued words back to back; called and returns at a negedge.
    task automatic push_stream();
        logic [31:0] w;
        int t;
        while (stim_q.size() > 0) begin
            w = stim_q.pop_front();
            bus.s_data  = w;
            bus.s_valid = 1'b1;
            t = 0;
            while (!bus.s_ready && t < 40) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (bus.s_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_accept: s_ready=%b required 1 for word %h", bus.s_ready, w);
                stim_q.delete();
            end
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_start();
        int t = 0;
        while (acc_start !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (acc_start !== 1'b1) begin
            errors++;
            $display("FAIL start_seen: acc_start=%b required 1", acc_start);
        end
    endtask

    // Core model: optional done during START (must be ignored), then real done.
    task automatic core_respond(input logic [31:0] r0, input logic [31:0] r1, input int lat, input bit early);
        if (early) acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        checks++;
        if (acc_start !== 1'b0 || bus.m_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: acc_start=%b m_valid=%b busy=%b required 0 0 1",
                     acc_start, bus.m_valid, busy);
        end
        repeat (lat) @(negedge clk);
        acc_out[0] = r0;
        acc_out[1] = r1;
        acc_done   = 1'b1;
        exp_q.push_back(r0);
        exp_q.push_back(r1);
        @(negedge clk);
        acc_done   = 1'b0;
        acc_out[0] = 32'hDEAD_BEEF;
        acc_out[1] = 32'hDEAD_BEEF;
    endtask

    // Pop expected results and compare as the controller drains them.
    task automatic drain(input int stall);
        int n = exp_q.size();
        logic [31:0] e;
        int t;
        bus.m_ready = 1'b0;
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            t = 0;
            while (bus.m_valid !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (k == 0) begin
                for (int s = 0; s < stall; s++) begin
                    checks++;
                    if (bus.m_valid !== 1'b1 || bus.m_data !== e) begin
                        errors++;
                        $display("FAIL drain_hold: m_valid=%b m_data=%h required 1 %h", bus.m_valid, bus.m_data, e);
                    end
                    @(negedge clk);
                end
            end
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== e) begin
                errors++;
                $display("FAIL drain_data: m_valid=%b m_data=%h required 1 %h", bus.m_valid, bus.m_data, e);
            end
            checks++;
            if (bus.m_last !== (k == n - 1)) begin
                errors++;
                $display("FAIL drain_last: m_last=%b required %b", bus.m_last, (k == n - 1));
            end
            $display("drain word %0d data=%h last=%b", k, bus.m_data, bus.m_last);
            bus.m_ready = 1'b1;
            @(negedge clk);
            bus.m_ready = 1'b0;
        end
        checks++;
        if (busy !== 1'b0 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: busy=%b m_valid=%b required 0 0", busy, bus.m_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 || acc_start !== 1'b0 ||
            busy !== 1'b0 || err !== 1'b0 || layer_prec !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: s_ready=%b m_valid=%b m_last=%b start=%b busy=%b err=%b prec=%b required all 0",
                     bus.s_ready, bus.m_valid, bus.m_last, acc_start, busy, err, layer_prec);
        end
        checks++;
        if (w8[1][31] !== 8'sd0 || bias[0] !== 32'sd0 || in4[0] !== 4'sd0 || wb[0][0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_arrays: w8=%h bias=%h in4=%h wb=%b required 0", w8[1][31], bias[0], in4[0], wb[0][0]);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_int8();
        int hb = hs_count;
        int sb = start_count;
        build_load(32'h0, 32'd5, 32'hFFFF_FFFD, 16, 32'h0101_0101, 32'h0101_0101, 8, 32'h0202_0202);
        push_stream();
        wait_start();
        core_respond(32'h11, 32'h22, 2, 1'b1);
        $display("int8 load words=%0d", hs_count - hb);
        checks++;
        if (hs_count - hb != 27 || start_count - sb != 1) begin
            errors++;
            $display("FAIL int8_counts: words=%0d starts=%0d required 27 1", hs_count - hb, start_count - sb);
        end
        checks++;
        if (start_cyc - last_hs_cyc != 1) begin
            errors++;
            $display("FAIL int8_start_latency: %0d cycles required 1", start_cyc - last_hs_cyc);
        end
        checks++;
        if (w8[1][31] !== 8'sd1 || w8[0][0] !== 8'sd1 || in8[31] !== 8'sd2 || layer_prec !== 2'b00) begin
            errors++;
            $display("FAIL int8_arrays: w8=%0d in8=%0d prec=%b required 1 2 00", w8[1][31], in8[31], layer_prec);
        end
        checks++;
        if (bias[0] !== 32'sd5 || bias[1] !== -32'sd3) begin
            errors++;
            $display("FAIL int8_bias: %0d %0d required 5 -3", bias[0], bias[1]);
        end
        drain(3);
    endtask

    task automatic test_int4_bin();
        int hb = hs_count;
        build_load(32'h1, 32'd7, 32'd8, 8, 32'h8765_4321, 32'h0, 4, 32'h1111_1111);
        push_stream();
        wait_start();
        core_respond(32'h100, 32'h200, 0, 1'b0);
        $display("int4 load words=%0d", hs_count - hb);
        checks++;
        if (hs_count - hb != 15) begin
            errors++;
            $display("FAIL int4_words: %0d required 15", hs_count - hb);
        end
        checks++;
        if (w4[0][0] !== 4'sd1 || w4[0][1] !== 4'sd2 || w4[0][7] !== -4'sd8 || in4[0] !== 4'sd1 || layer_prec !== 2'b01) begin
            errors++;
            $display("FAIL int4_unpack: w4[0]=%0d w4[1]=%0d w4[7]=%0d in4=%0d prec=%b required 1 2 -8 1 01",
                     w4[0][0], w4[0][1], w4[0][7], in4[0], layer_prec);
        end
        checks++;
        if (w8[1][31] !== 8'sd1) begin
            errors++;
            $display("FAIL int4_keeps_int8: w8=%0d required 1", w8[1][31]);
        end
        drain(0);

        hb = hs_count;
        build_load(32'h2, 32'd1, 32'd2, 2, 32'h0000_0001, 32'h8000_0000, 1, 32'hA5A5_A5A5);
        push_stream();
        wait_start();
        core_respond(32'h300, 32'h400, 1, 1'b0);
        $display("bin load words=%0d", hs_count - hb);
        checks++;
        if (hs_count - hb != 6) begin
            errors++;
            $display("FAIL bin_words: %0d required 6", hs_count - hb);
        end
        checks++;
        if (wb[0][0] !== 1'b1 || wb[1][31] !== 1'b1 || wb[1][0] !== 1'b0 ||
            inb[0] !== 1'b1 || inb[1] !== 1'b0 || inb[31] !== 1'b1 || layer_prec !== 2'b10) begin
            errors++;
            $display("FAIL bin_unpack: wb=%b%b%b inb=%b%b%b prec=%b required 110 101 10",
                     wb[0][0], wb[1][31], wb[1][0], inb[0], inb[1], inb[31], layer_prec);
        end
        checks++;
        if (w4[0][7] !== -4'sd8) begin
            errors++;
            $display("FAIL bin_keeps_int4: w4=%0d required -8", w4[0][7]);
        end
        drain(0);
    endtask

    task automatic test_bad_config();
        stim_q.push_back(32'h3);
        push_stream();
        $display("bad config sent");
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_cfg_flag: err=%b busy=%b required 1 0", err, busy);
        end
        checks++;
        if (layer_prec !== 2'b10 || w8[1][31] !== 8'sd1 || wb[1][31] !== 1'b1) begin
            errors++;
            $display("FAIL bad_cfg_hold: prec=%b w8=%0d wb=%b required 10 1 1", layer_prec, w8[1][31], wb[1][31]);
        end
        // Valid config then an input gap before the rest of the load.
        stim_q.push_back(32'h0);
        push_stream();
        repeat (2) @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1 || layer_prec !== 2'b00) begin
            errors++;
            $display("FAIL bad_cfg_clear: err=%b busy=%b prec=%b required 0 1 00", err, busy, layer_prec);
        end
        stim_q.push_back(32'd4);
        stim_q.push_back(32'd6);
        for (int i = 0; i < 16; i++) stim_q.push_back(32'h0303_0303);
        for (int i = 0; i < 8; i++)  stim_q.push_back(32'h0404_0404);
        push_stream();
        wait_start();
        core_respond(32'h33, 32'h44, 0, 1'b0);
        checks++;
        if (w8[0][5] !== 8'sd3 || in8[0] !== 8'sd4 || bias[1] !== 32'sd6) begin
            errors++;
            $display("FAIL gap_load: w8=%0d in8=%0d bias=%0d required 3 4 6", w8[0][5], in8[0], bias[1]);
        end
        drain(0);
    endtask

    task automatic test_reset_mid_wgt();
        build_load(32'h0, 32'd9, 32'd9, 5, 32'h0101_0101, 32'h0101_0101, 0, 32'h0);
        push_stream();
        checks++;
        if (w8[0][0] !== 8'sd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_wgt_partial: w8=%0d busy=%b required 1 1", w8[0][0], busy);
        end
        rst = 1'b1;
        #1;
        $display("reset asserted mid WGT");
        checks++;
        if (busy !== 1'b0 || bus.s_ready !== 1'b0 || err !== 1'b0 || layer_prec !== 2'b00 ||
            bus.m_valid !== 1'b0 || acc_start !== 1'b0) begin
            errors++;
            $display("FAIL mid_wgt_outputs: busy=%b s_ready=%b err=%b prec=%b m_valid=%b start=%b required all 0",
                     busy, bus.s_ready, err, layer_prec, bus.m_valid, acc_start);
        end
        checks++;
        if (w8[0][0] !== 8'sd0 || in8[0] !== 8'sd0 || bias[0] !== 32'sd0 || w4[0][7] !== 4'sd0 || wb[1][31] !== 1'b0) begin
            errors++;
            $display("FAIL mid_wgt_arrays: w8=%0d in8=%0d bias=%0d w4=%0d wb=%b required 0",
                     w8[0][0], in8[0], bias[0], w4[0][7], wb[1][31]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        build_load(32'h0, 32'd5, 32'hFFFF_FFFD, 16, 32'h0101_0101, 32'h0101_0101, 8, 32'h0202_0202);
        push_stream();
        wait_start();
        core_respond(32'h55, 32'h66, 1, 1'b0);
        checks++;
        if (w8[1][31] !== 8'sd1 || in8[31] !== 8'sd2) begin
            errors++;
            $display("FAIL reload: w8=%0d in8=%0d required 1 2", w8[1][31], in8[31]);
        end
        drain(0);
    endtask

    task automatic test_weight_keep();
        int hb = hs_count;
        int sb = start_count;
`ifdef QNN_WEIGHT_KEEP_EN
        build_load(32'h4, 32'd1, 32'd1, 0, 32'h0, 32'h0, 8, 32'h0505_0505);
`else
        build_load(32'h4, 32'd1, 32'd1, 16, 32'h0606_0606, 32'h0606_0606, 8, 32'h0505_0505);
`endif
        push_stream();
        wait_start();
        core_respond(32'h77, 32'h88, 0, 1'b0);
        $display("keep cfg load words=%0d", hs_count - hb);
        checks++;
`ifdef QNN_WEIGHT_KEEP_EN
        if (hs_count - hb != 11 || start_count - sb != 1 || w8[1][31] !== 8'sd1 || in8[3] !== 8'sd5) begin
            errors++;
            $display("FAIL weight_keep: words=%0d starts=%0d w8=%0d in8=%0d required 11 1 1 5",
                     hs_count - hb, start_count - sb, w8[1][31], in8[3]);
        end
`else
        if (hs_count - hb != 27 || start_count - sb != 1 || w8[1][31] !== 8'sd6 || in8[3] !== 8'sd5) begin
            errors++;
            $display("FAIL weight_keep: words=%0d starts=%0d w8=%0d in8=%0d required 27 1 6 5",
                     hs_count - hb, start_count - sb, w8[1][31], in8[3]);
        end
`endif
        drain(0);
    endtask

    initial begin
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        acc_done    = 1'b0;
        acc_out[0]  = '0;
        acc_out[1]  = '0;
        test_reset();
        test_int8();
        test_int4_bin();
        test_bad_config();
        test_reset_mid_wgt();
        test_weight_keep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qnn_stream_ctrl.md
Name: qnn_stream_ctrl

Overview:
- Streaming front-end and sequencer for the QNN accelerator core.
- Accepts one 32-bit AXI-Stream-style input carrying a config word, then biases, weights and activations.
- Unpacks the words into INT8, INT4 or BIN arrays that drive the core, pulses the core's start, waits for its done, and streams the OUT_DIM results back.
- Replaces the static, zero-initialised test harness around the core with a loadable, reusable one.

Parameters:
IN_DIM, 64, input vector length; must be a multiple of 32
OUT_DIM, 16, output neurons
NUM_PE, 1, forwarded to the core; not used internally
WORD_W, 32, stream word width; fixed at 32

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
s_data  input  32  input stream word
s_valid  input  1  input word valid
s_ready  output  1  input word accepted when s_valid && s_ready
m_data  output  32  output result word
m_valid  output  1  output word valid
m_ready  input  1  downstream accepts
m_last  output  1  marks out[OUT_DIM-1]
acc_start  output  1  one-cycle start pulse to the core
acc_done  input  1  core completion
layer_prec  output  2  00 INT8, 01 INT4, 10 BIN
in8/w8, in4/w4, inb/wb  output  arrays  core operands: [IN_DIM] and [OUT_DIM][IN_DIM] of 8b signed, 4b signed and 1b
bias  output  [OUT_DIM] x 32 signed  core biases
acc_out  input  [OUT_DIM] x 32 signed  core results
busy  output  1  high in every state except IDLE
err  output  1  sticky bad-config flag; cleared by the next valid config word or by reset

Behaviour:
- Reset, asynchronous:
  - state IDLE; s_ready=0, m_valid=0, m_last=0, acc_start=0, busy=0, err=0, layer_prec=00.
  - All operand and bias arrays cleared to 0.
  - Reset mid-load or mid-run aborts immediately.
- States: IDLE, CFG, BIAS, WGT, ACT, START, WAIT, DRAIN.
- IDLE→CFG when s_valid is seen; s_ready=1 in CFG.
- Config word: bits[1:0]=prec, bit[2]=keep_w (see optional feature), other bits ignored.
- prec=11 is rejected:
  - err set; the word is consumed; return to IDLE.
  - layer_prec and arrays are left unchanged.
- Element packing, least-significant element first in each word:
  - epw (elements per word) = 4 for INT8, 8 for INT4, 32 for BIN.
  - Element k of a word occupies bits [k*ew +: ew], where ew = 8, 4 or 1.
- BIAS: OUT_DIM words, bias[0] first.
- WGT: OUT_DIM*IN_DIM/epw words, row-major w[o][i], i fastest.
- ACT: IN_DIM/epw words.
- Only the arrays for the selected precision are written; the other precisions' arrays hold their values.
- s_ready=1 throughout CFG/BIAS/WGT/ACT; counters advance only on a handshake. s_valid gaps stall without side effects.
- After the last ACT handshake:
  - START: acc_start=1 for exactly one cycle, s_ready=0.
  - WAIT: hold until acc_done=1.
  - On acc_done=1, capture acc_out into an output register bank and go to DRAIN.
- A done that arrives in the START cycle itself is ignored.
- DRAIN:
  - m_data = out[idx]; m_valid held high until the handshake.
  - m_last=1 on idx=OUT_DIM-1.
  - After the last handshake, return to IDLE the next cycle.
- m_data must stay stable while m_valid && !m_ready.
- Throughput: one word per cycle in every load state.
- Minimum latency from the final ACT word to the first m_valid = 2 + core latency.
- Counters are sized $clog2(max word count)+1; no wrap occurs within a phase.

Optional Feature:
- Macro QNN_WEIGHT_KEEP_EN.
- Defined:
  - Config bit[2]=1 skips WGT (CFG→BIAS→ACT) and the previously loaded weights of that precision are reused.
  - keep_w=1 with no prior weight load for that precision is allowed; the weights are then the reset zeros.
- Undefined: bit[2] is ignored and WGT always runs.

Decomposition:
- Package qnn_pkg holds:
  - typedef prec_e {PREC_INT8, PREC_INT4, PREC_BIN}.
  - State enum ctrl_state_e.
  - Constant CFG_KEEP_BIT=2.
  - Function words_per_vec(prec, len), returning len/epw.
- Sub-module qnn_word_unpack: combinational split of one 32-bit word into 4x8b / 8x4b / 32x1b lanes.

Test Plan:
(Bench uses IN_DIM=32, OUT_DIM=2.)
- INT8 load:
  - Stimulus: cfg 0x0; biases 5, -3; 16 weight words of 0x01010101; 8 activation words of 0x02020202.
  - Response: acc_start pulses once, exactly 1 cycle after the 26th data word; w8[1][31]=1, in8[31]=2, layer_prec=00.
- INT4/BIN packing:
  - Stimulus: cfg 1, weight word 0x8765_4321.
  - Response: w4[0][0]=1, w4[0][7]=-8; BIN cfg 2 loads 2 weight words and 1 activation word.
- Drain backpressure:
  - Stimulus: core returns 0x11 and 0x22; m_ready low for 3 cycles.
  - Response: m_data holds 0x11 for all 3 cycles; m_last=1 only with 0x22; busy falls after the second handshake.
- Bad config:
  - Stimulus: cfg 0x3.
  - Response: err=1, state back to IDLE, arrays unchanged; a following cfg 0x0 clears err.
- Reset mid-WGT:
  - Stimulus: rst asserted after 5 weight words.
  - Response: all outputs at their reset values and busy=0 immediately; a full reload then works.
- QNN_WEIGHT_KEEP_EN:
  - Stimulus: cfg 0x4 after an INT8 load.
  - Response: only 2 bias words and 8 activation words are accepted before acc_start; w8 unchanged.
